// File: rtl/uart_frame_parser_if.sv
// Byte link from the UART receiver plus the parsed-frame outputs toward the application datapath.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 16
);
  logic                       rx_interrupt;
  logic [7:0]                 rx_data;
  logic                       parity_err;
  logic                       clear_interrupt;
  logic [7:0]                 cmd;
  logic [7:0]                 pay_data;
  logic                       pay_valid;
  logic [$clog2(MAX_LEN)-1:0] pay_idx;
  logic                       frame_done;
  logic                       frame_err;
  logic                       busy;

  modport master (
    output rx_interrupt, rx_data, parity_err,
    input  clear_interrupt, cmd, pay_data, pay_valid, pay_idx, frame_done, frame_err, busy
  );

  modport slave (
    input  rx_interrupt, rx_data, parity_err,
    output clear_interrupt, cmd, pay_data, pay_valid, pay_idx, frame_done, frame_err, busy
  );
endinterface

// File: rtl/uart_frame_parser.sv
// Parses FE LEN CMD PAYLOAD EF frames from the UART; define PARITY_CHECK_EN to abort frames on parity errors.
// All outputs registered one cycle after byte acceptance; one byte per rx_interrupt assertion, acked by clear_interrupt.
module uart_frame_parser #(
  parameter int         MAX_LEN    = 16,
  parameter logic [7:0] START_BYTE = 8'hFE,
  parameter logic [7:0] END_BYTE   = 8'hEF
) (
  input logic               clk,
  input logic               rst,
  uart_frame_parser_if.slave bus
);
  typedef logic [7:0] data_t;

  localparam int         IW        = $clog2(MAX_LEN);
  localparam int         CW        = $clog2(MAX_LEN + 1);
  localparam logic [8:0] MAX_LEN_B = 9'(MAX_LEN);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_CMD, S_DATA, S_END} state_t;

  state_t        state;
  logic          ack_pending;
  logic [CW-1:0] remaining;
  logic [IW-1:0] idx;
  data_t         rx_byte;
  logic          accept;
  logic          len_ok;
  logic          par_abort;

  assign rx_byte = bus.rx_data;
  assign accept  = bus.rx_interrupt && !ack_pending;
  assign len_ok  = (rx_byte != 8'd0) && ({1'b0, rx_byte} <= MAX_LEN_B);

`ifdef PARITY_CHECK_EN
  assign par_abort = bus.parity_err && (state != S_IDLE);
`else
  logic parity_unused;
  assign parity_unused = bus.parity_err;
  assign par_abort     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= S_IDLE;
      ack_pending         <= 1'b0;
      remaining           <= '0;
      idx                 <= '0;
      bus.clear_interrupt <= 1'b0;
      bus.cmd             <= '0;
      bus.pay_data        <= '0;
      bus.pay_valid       <= 1'b0;
      bus.pay_idx         <= '0;
      bus.frame_done      <= 1'b0;
      bus.frame_err       <= 1'b0;
      bus.busy            <= 1'b0;
    end else begin
      bus.clear_interrupt <= 1'b0;
      bus.pay_valid       <= 1'b0;
      bus.frame_done      <= 1'b0;
      bus.frame_err       <= 1'b0;
      // The UART holds rx_interrupt until it sees the ack, so re-arm only once it drops.
      if (ack_pending && !bus.rx_interrupt) ack_pending <= 1'b0;

      if (accept) begin
        bus.clear_interrupt <= 1'b1;
        ack_pending         <= 1'b1;
        if (par_abort) begin
          bus.frame_err <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= S_IDLE;
        end else begin
          case (state)
            S_IDLE: begin
              if (rx_byte == START_BYTE) begin
                idx         <= '0;
                bus.pay_idx <= '0;
                bus.busy    <= 1'b1;
                state       <= S_LEN;
              end
            end
            S_LEN: begin
              if (len_ok) begin
                remaining <= rx_byte[CW-1:0];
                state     <= S_CMD;
              end else begin
                bus.frame_err <= 1'b1;
                bus.busy      <= 1'b0;
                state         <= S_IDLE;
              end
            end
            S_CMD: begin
              bus.cmd   <= rx_byte;
              remaining <= remaining - 1'b1;
              state     <= (remaining == CW'(1)) ? S_END : S_DATA;
            end
            S_DATA: begin
              bus.pay_data  <= rx_byte;
              bus.pay_valid <= 1'b1;
              bus.pay_idx   <= idx;
              idx           <= idx + 1'b1;
              remaining     <= remaining - 1'b1;
              if (remaining == CW'(1)) state <= S_END;
            end
            S_END: begin
              if (rx_byte == END_BYTE) bus.frame_done <= 1'b1;
              else                     bus.frame_err  <= 1'b1;
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
            default: begin
              bus.busy <= 1'b0;
              state    <= S_IDLE;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized and directed bench for uart_frame_parser against a frame-level stream model.
module tb_uart_frame_parser;
  localparam int         MAX_LEN = 16;
  localparam logic [7:0] SB      = 8'hFE;
  localparam logic [7:0] EB      = 8'hEF;

  logic clk;
  logic rst;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .START_BYTE(SB), .END_BYTE(EB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         pv;
    logic [7:0] pd;
    int         pidx;
    bit         done;
    bit         err;
    logic [7:0] cmd;
    bit         busy;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] seg_b[$];
  bit         seg_p[$];
  int         pv_dat_log[$];
  int         pv_idx_log[$];
  logic [7:0] mcmd;
  bit         last_busy;
  int         hold_fixed;
  int         n_checks = 0;
  int         n_errors = 0;
  int         n_ack = 0, n_pv = 0, n_done = 0, n_err = 0;
  int         s_ack, s_pv, s_done, s_err, s_log;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit par_bad(input int i);
`ifdef PARITY_CHECK_EN
    return seg_p[i];
`else
    return 1'b0;
`endif
  endfunction

  task automatic emit(input bit pv, input logic [7:0] pd, input int pi, input bit dn, input bit er, input bit bz);
    exp_q.push_back('{pv, pd, pi, dn, er, mcmd, bz});
  endtask

  // Walks the byte stream frame by frame; one expectation per byte, in acceptance order.
  task automatic model_run();
    int i = 0;
    int n = seg_b.size();
    int L;
    bit aborted;
    while (i < n) begin
      if (seg_b[i] != SB) begin
        emit(0, 0, 0, 0, 0, 0); i++; continue;
      end
      emit(0, 0, 0, 0, 0, 1); i++;
      if (i >= n) break;
      L = int'(seg_b[i]);
      if (par_bad(i) || L == 0 || L > MAX_LEN) begin
        emit(0, 0, 0, 0, 1, 0); i++; continue;
      end
      emit(0, 0, 0, 0, 0, 1); i++;
      aborted = 0;
      for (int k = 0; k < L && i < n; k++) begin
        if (par_bad(i)) begin
          emit(0, 0, 0, 0, 1, 0); i++; aborted = 1; break;
        end
        if (k == 0) begin
          mcmd = seg_b[i];
          emit(0, 0, 0, 0, 0, 1);
        end else begin
          emit(1, seg_b[i], k - 1, 0, 0, 1);
        end
        i++;
      end
      if (aborted || i >= n) continue;
      if (!par_bad(i) && seg_b[i] == EB) emit(0, 0, 0, 1, 0, 0);
      else                               emit(0, 0, 0, 0, 1, 0);
      i++;
    end
  endtask

  // Compare process: every ack cycle must match the next model entry; other cycles stay quiet.
  always @(negedge clk) begin
    if (rst) begin
      last_busy = 1'b0;
    end else if (bus.clear_interrupt) begin
      n_ack++;
      if (bus.pay_valid) begin
        n_pv++;
        pv_dat_log.push_back(int'(bus.pay_data));
        pv_idx_log.push_back(int'(bus.pay_idx));
      end
      if (bus.frame_done) n_done++;
      if (bus.frame_err)  n_err++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("pay_valid", bus.pay_valid, cur.pv);
        if (cur.pv) begin
          chk("pay_data", bus.pay_data, cur.pd);
          chk("pay_idx", bus.pay_idx, cur.pidx);
        end
        chk("frame_done", bus.frame_done, cur.done);
        chk("frame_err", bus.frame_err, cur.err);
        chk("cmd", bus.cmd, cur.cmd);
        chk("busy", bus.busy, cur.busy);
        last_busy = cur.busy;
      end
    end else begin
      chk("idle_strobes", {bus.pay_valid, bus.frame_done, bus.frame_err}, 0);
      chk("busy_hold", bus.busy, last_busy);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit p, input int hold);
    int t = 0;
    @(negedge clk);
    bus.rx_data      = b;
    bus.parity_err   = p;
    bus.rx_interrupt = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.clear_interrupt && t < 20);
    if (!bus.clear_interrupt) chk("ack_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    bus.rx_interrupt = 1'b0;
    bus.rx_data      = 8'($urandom);
    bus.parity_err   = 1'b0;
    repeat (1 + $urandom % 3) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] b, input bit p = 1'b0);
    seg_b.push_back(b);
    seg_p.push_back(p);
  endtask

  task automatic play();
    model_run();
    for (int i = 0; i < seg_b.size(); i++)
      send_byte(seg_b[i], seg_p[i], (hold_fixed >= 0) ? hold_fixed : int'($urandom % 3));
    repeat (3) @(negedge clk);
    chk("exp_drain", exp_q.size(), 0);
    exp_q.delete();
    seg_b.delete();
    seg_p.delete();
  endtask

  task automatic snap();
    s_ack = n_ack; s_pv = n_pv; s_done = n_done; s_err = n_err; s_log = pv_dat_log.size();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_clear"}, bus.clear_interrupt, 0);
    chk({tag, "_cmd"}, bus.cmd, 0);
    chk({tag, "_pay_data"}, bus.pay_data, 0);
    chk({tag, "_pay_valid"}, bus.pay_valid, 0);
    chk({tag, "_pay_idx"}, bus.pay_idx, 0);
    chk({tag, "_done"}, bus.frame_done, 0);
    chk({tag, "_err"}, bus.frame_err, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  function automatic bit rand_par();
`ifdef PARITY_CHECK_EN
    return ($urandom % 25) == 0;
`else
    return 1'($urandom);
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] j;
    logic [7:0] L;
    int sel;
    rst = 1'b1;
    bus.rx_interrupt = 1'b0;
    bus.rx_data = 8'h00;
    bus.parity_err = 1'b0;
    hold_fixed = -1;
    mcmd = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Two payload bytes
    snap();
    add(8'hFE); add(8'h03); add(8'hA5); add(8'h11); add(8'h22); add(8'hEF);
    play();
    chk("f1_cmd", bus.cmd, 8'hA5);
    chk("f1_acks", n_ack - s_ack, 6);
    chk("f1_pv_count", n_pv - s_pv, 2);
    chk("f1_done_count", n_done - s_done, 1);
    if (pv_dat_log.size() >= s_log + 2) begin
      chk("f1_pd0", pv_dat_log[s_log], 8'h11);
      chk("f1_idx0", pv_idx_log[s_log], 0);
      chk("f1_pd1", pv_dat_log[s_log + 1], 8'h22);
      chk("f1_idx1", pv_idx_log[s_log + 1], 1);
    end else begin
      chk("f1_pv_log", pv_dat_log.size() - s_log, 2);
    end

    // Command only
    snap();
    add(8'hFE); add(8'h01); add(8'h5A); add(8'hEF);
    play();
    chk("f2_cmd", bus.cmd, 8'h5A);
    chk("f2_pv_count", n_pv - s_pv, 0);
    chk("f2_done_count", n_done - s_done, 1);

    // Illegal LEN values
    snap();
    add(8'hFE); add(8'h00); add(8'hFE); add(8'h11);
    play();
    chk("badlen_err_count", n_err - s_err, 2);
    chk("badlen_busy", bus.busy, 0);

    // Bad end byte, then recovery
    snap();
    add(8'hFE); add(8'h02); add(8'hB0); add(8'h33); add(8'h44);
    add(8'hFE); add(8'h01); add(8'hC1); add(8'hEF);
    play();
    chk("badend_err_count", n_err - s_err, 1);
    chk("badend_pv_count", n_pv - s_pv, 1);
    chk("badend_done_count", n_done - s_done, 1);
    chk("badend_cmd", bus.cmd, 8'hC1);

    // Long-held interrupt in IDLE
    snap();
    hold_fixed = 10;
    add(8'h77);
    play();
    hold_fixed = -1;
    chk("hold_acks", n_ack - s_ack, 1);
    chk("hold_err_count", n_err - s_err, 0);
    chk("hold_busy", bus.busy, 0);

    // Parity error on a payload byte
    snap();
    add(8'hFE); add(8'h03); add(8'h01); add(8'hAA, 1'b1); add(8'hBB); add(8'hEF);
    play();
`ifdef PARITY_CHECK_EN
    chk("parity_err_count", n_err - s_err, 1);
    chk("parity_done_count", n_done - s_done, 0);
`else
    chk("parity_err_count", n_err - s_err, 0);
    chk("parity_done_count", n_done - s_done, 1);
`endif

    // Reset mid-frame, then a clean frame
    add(8'hFE); add(8'h04); add(8'h01);
    play();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    mcmd = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    add(8'hFE); add(8'h01); add(8'h02); add(8'hEF);
    play();
    chk("postrst_done_count", n_done - s_done, 1);
    chk("postrst_err_count", n_err - s_err, 0);
    chk("postrst_cmd", bus.cmd, 8'h02);

    // Random frames: junk, bad lengths, bad end bytes, random payload including FE
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom % 3) begin
        j = 8'($urandom);
        if (j == SB) j = 8'h00;
        add(j, rand_par());
      end
      add(SB, rand_par());
      sel = int'($urandom % 10);
      if (sel == 0)      L = 8'd0;
      else if (sel == 1) L = 8'(17 + $urandom % 239);
      else               L = 8'(1 + $urandom % MAX_LEN);
      add(L, rand_par());
      if (L != 0 && int'(L) <= MAX_LEN) begin
        for (int k = 0; k < int'(L); k++) add(8'($urandom), rand_par());
        if ($urandom % 5 == 0) begin
          j = 8'($urandom);
          if (j == EB) j = 8'h00;
          add(j, rand_par());
        end else begin
          add(EB, rand_par());
        end
      end
    end
    play();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART receiver in p03.
- Consumes received bytes (rx_interrupt/rx_data), acknowledges each via clear_interrupt, and parses framed commands: 0xFE, LEN, CMD, PAYLOAD[LEN-1], 0xEF.
- Streams payload bytes to the application datapath, then reports frame completion or error so downstream logic commits or discards the payload.

Parameters:
- MAX_LEN, 16, maximum legal LEN value; LEN counts CMD plus payload bytes.
- START_BYTE, 8'hFE, frame start delimiter.
- END_BYTE, 8'hEF, frame end delimiter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- rx_interrupt  input  1  UART byte-available level; held until cleared
- rx_data  input  8 (data_t)  received byte; valid while rx_interrupt=1
- parity_err  input  1  UART parity flag for the current byte
- clear_interrupt  output  1  one-cycle acknowledge to the UART
- cmd  output  8  command byte of the current frame; held until the next CMD capture
- pay_data  output  8  payload byte
- pay_valid  output  1  one-cycle strobe per payload byte
- pay_idx  output  $clog2(MAX_LEN)  payload index, starting at 0
- frame_done  output  1  one-cycle pulse on a valid END_BYTE
- frame_err  output  1  one-cycle pulse on any framing error
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, cmd=0, state=IDLE, internal counters 0, ack_pending=0.
- Byte acceptance:
  - A byte is accepted on a cycle with rx_interrupt=1 and ack_pending=0.
  - On the next cycle clear_interrupt=1 for exactly one cycle and ack_pending sets.
  - ack_pending clears on the first cycle rx_interrupt=0.
  - No byte is accepted while ack_pending=1, so each byte is consumed exactly once.
- All outputs are registered. Each output reacts one cycle after acceptance, in the same cycle as clear_interrupt.
- State machine:
  - IDLE: START_BYTE -> LEN. Any other byte is dropped silently (no error).
  - LEN: byte in 1..MAX_LEN -> store as remaining count, go to CMD. A byte of 0 or >MAX_LEN -> frame_err, go to IDLE.
  - CMD: load cmd, decrement remaining. Go to DATA if remaining>0 after the decrement, else to END.
  - DATA: pay_data=byte, pay_valid=1, pay_idx=current index; increment index, decrement remaining; at remaining=0 go to END.
  - END: END_BYTE -> frame_done, go to IDLE. Any other byte -> frame_err, go to IDLE.
- START_BYTE inside LEN/CMD/DATA is treated as data, not a resync. LEN=START_BYTE is >MAX_LEN unless MAX_LEN>=254, and is then an error.
- frame_done and frame_err are mutually exclusive and never pulse in the same cycle as pay_valid.
- pay_idx resets to 0 on entry to LEN.
- Async reset mid-frame returns to IDLE immediately. Any partial payload is abandoned with no frame_err.
- An rx_interrupt already high when reset deasserts is accepted normally.

Optional Feature:
- Macro PARITY_CHECK_EN.
- Defined: an accepted byte with parity_err=1 in any non-IDLE state produces frame_err, goes to IDLE, and is still acknowledged. In IDLE the byte is dropped silently.
- Undefined: parity_err is ignored and the port remains present but unused.

Test Plan:
- Frame FE 03 A5 11 22 EF -> cmd=A5; pay_valid twice (11 @idx0, 22 @idx1); frame_done once; six clear_interrupt pulses.
- Frame FE 01 5A EF -> cmd=5A, no pay_valid, frame_done.
- FE 00 and FE 11 (MAX_LEN=16) -> frame_err one cycle after the LEN byte, state IDLE, busy=0.
- FE 02 B0 33 44 (bad end byte) -> pay_valid for 33, then frame_err on 44; the next FE 01 C1 EF -> frame_done with cmd=C1.
- rx_interrupt held high 10 cycles with one byte 77 in IDLE -> exactly one clear_interrupt, byte dropped, no errors.
- With PARITY_CHECK_EN: parity_err=1 on a payload byte of FE 03 01 AA BB EF -> frame_err, no frame_done. Without the macro the same frame -> frame_done.
- Reset asserted after FE 04 01 -> all outputs 0. The following FE 01 02 EF -> frame_done.
